// File: rtl/uart_pkt_rx_ctrl_if.sv
// Byte-stream in / packet-stream out bundle for uart_pkt_rx_ctrl.
// The slave modport is the controller. The master modport is the UART side plus the downstream consumer.
interface uart_pkt_rx_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_last;
    logic       pkt_ready;
    logic [7:0] pkt_len;
    logic       busy;
    logic       err_checksum;
    logic       err_length;
    logic       err_timeout;
    logic       err_overrun;

    modport slave (
        input  rx_data, rx_valid, pkt_ready,
        output pkt_data, pkt_valid, pkt_last, pkt_len, busy,
               err_checksum, err_length, err_timeout, err_overrun
    );

    modport master (
        output rx_data, rx_valid, pkt_ready,
        input  pkt_data, pkt_valid, pkt_last, pkt_len, busy,
               err_checksum, err_length, err_timeout, err_overrun
    );
endinterface

// File: rtl/uart_pkt_rx_ctrl.sv
// Framed packet receiver: sync byte, then length, payload and XOR checksum. Verified payload is replayed on a valid/ready stream.
// Defining UART_PKT_TIMEOUT_EN adds an inter-byte timeout that aborts stalled frames.
module uart_pkt_rx_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 104_160
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_pkt_rx_ctrl_if.slave bus
);
    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2 || TIMEOUT_CLKS >= (1 << 24)) begin : g_param_chk
        $error("uart_pkt_rx_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

    state_t     r_state, w_nstate;
    logic [7:0] r_len, w_len_n;
    logic [7:0] r_xor, w_xor_n;
    logic [7:0] r_idx, w_idx_n;
    logic [7:0] r_buf [DEPTH];
    logic [7:0] r_pkt_data, w_data_n;
    logic       r_pkt_valid, w_valid_n;
    logic       r_pkt_last, w_last_n;
    logic [7:0] r_pkt_len;
    logic       r_busy;
    logic       r_err_ck, r_err_len, r_err_tmo, r_err_ovr;
    logic       w_err_ck, w_err_len, w_err_tmo, w_err_ovr;
    logic       w_wr_en;
    logic       w_tmo_fire;
    logic [7:0] w_rd_nxt;

    assign w_rd_nxt = r_idx + 8'd1;

`ifdef UART_PKT_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CLKS - 1);
    logic [23:0] r_tmo;
    logic        w_timed;

    assign w_timed    = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign w_tmo_fire = w_timed && !bus.rx_valid && (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_tmo <= '0;
        else if (!w_timed || bus.rx_valid || w_tmo_fire) r_tmo <= '0;
        else                                          r_tmo <= r_tmo + 24'd1;
    end
`else
    assign w_tmo_fire = 1'b0;
`endif

    always_comb begin
        w_nstate  = r_state;
        w_len_n   = r_len;
        w_xor_n   = r_xor;
        w_idx_n   = r_idx;
        w_wr_en   = 1'b0;
        w_data_n  = r_pkt_data;
        w_valid_n = r_pkt_valid;
        w_last_n  = r_pkt_last;
        w_err_ck  = 1'b0;
        w_err_len = 1'b0;
        w_err_ovr = 1'b0;
        w_err_tmo = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) w_nstate = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_L) begin
                        w_len_n  = bus.rx_data;
                        w_xor_n  = bus.rx_data;
                        w_idx_n  = 8'd0;
                        w_nstate = S_PAYLOAD;
                    end else begin
                        w_err_len = 1'b1;
                        w_nstate  = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_valid) begin
                    w_wr_en = 1'b1;
                    w_xor_n = r_xor ^ bus.rx_data;
                    w_idx_n = w_rd_nxt;
                    if (w_rd_nxt == r_len) w_nstate = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == r_xor) begin
                        w_nstate  = S_DRAIN;
                        w_idx_n   = 8'd0;
                        w_valid_n = 1'b1;
                        w_data_n  = r_buf[0];
                        w_last_n  = (r_len == 8'd1);
                    end else begin
                        w_err_ck = 1'b1;
                        w_nstate = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                w_err_ovr = bus.rx_valid;
                if (r_pkt_valid && bus.pkt_ready) begin
                    if (r_pkt_last) begin
                        w_nstate  = S_IDLE;
                        w_valid_n = 1'b0;
                        w_last_n  = 1'b0;
                        w_data_n  = 8'd0;
                        w_idx_n   = 8'd0;
                    end else begin
                        // Prefetch the next byte so a ready consumer sees one byte per clock.
                        w_idx_n  = w_rd_nxt;
                        w_data_n = r_buf[w_rd_nxt[AW-1:0]];
                        w_last_n = ((r_idx + 8'd2) == r_len);
                    end
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        if (w_tmo_fire) begin
            w_nstate  = S_IDLE;
            w_err_tmo = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_xor       <= '0;
            r_idx       <= '0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_last  <= 1'b0;
            r_pkt_len   <= '0;
            r_busy      <= 1'b0;
            r_err_ck    <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_err_ovr   <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_len       <= w_len_n;
            r_xor       <= w_xor_n;
            r_idx       <= w_idx_n;
            r_pkt_data  <= w_data_n;
            r_pkt_valid <= w_valid_n;
            r_pkt_last  <= w_last_n;
            r_pkt_len   <= (w_nstate == S_DRAIN) ? w_len_n : 8'd0;
            r_busy      <= (w_nstate != S_IDLE);
            r_err_ck    <= w_err_ck;
            r_err_len   <= w_err_len;
            r_err_tmo   <= w_err_tmo;
            r_err_ovr   <= w_err_ovr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[r_idx[AW-1:0]] <= bus.rx_data;
    end

    assign bus.pkt_data     = r_pkt_data;
    assign bus.pkt_valid    = r_pkt_valid;
    assign bus.pkt_last     = r_pkt_last;
    assign bus.pkt_len      = r_pkt_len;
    assign bus.busy         = r_busy;
    assign bus.err_checksum = r_err_ck;
    assign bus.err_length   = r_err_len;
    assign bus.err_timeout  = r_err_tmo;
    assign bus.err_overrun  = r_err_ovr;
endmodule

// File: doc/uart_pkt_rx_ctrl.md
# uart_pkt_rx_ctrl

- Packet receive controller behind `uart_rx`.
- Consumes its byte stream (`data_out`/`data_valid`) and hunts for a sync byte, then reads the length, payload and XOR checksum.
- Buffers the payload internally. Releases it downstream over a valid/ready stream only after the checksum verifies.
- Malformed, oversized or stalled frames are discarded and flagged with single-cycle error pulses.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 16: maximum payload bytes (1..255). Sets the buffer depth.
- `TIMEOUT_CLKS`, default 104_160: inter-byte timeout in clocks, two character times at 9600 bps / 50 MHz. Must be < 2^24.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `rx_data` in 8: byte from `uart_rx` `data_out`.
- `rx_valid` in 1: one-cycle pulse from `uart_rx` `data_valid`.
- `pkt_data` out 8: payload byte.
- `pkt_valid` out 1: `pkt_data` valid.
- `pkt_last` out 1: final payload byte of packet.
- `pkt_ready` in 1: downstream accepts byte.
- `pkt_len` out 8: length of packet being drained.
- `busy` out 1: state != IDLE.
- `err_checksum` out 1: pulse, checksum mismatch.
- `err_length` out 1: pulse, length 0 or > `MAX_LEN`.
- `err_timeout` out 1: pulse, inter-byte timeout.
- `err_overrun` out 1: pulse, byte arrived while draining and was dropped.

## Operation
- States: IDLE, LEN, PAYLOAD, CHECK, DRAIN. All transitions occur on an `rx_valid` cycle unless stated otherwise.
- IDLE:
  - `rx_data == SYNC_BYTE` -> LEN.
  - Other bytes are silently ignored.
- LEN:
  - Byte L in 1..`MAX_LEN` -> store L, set running XOR := L, index := 0, go to PAYLOAD.
  - Otherwise pulse `err_length` and go to IDLE.
- PAYLOAD:
  - Write byte to `buf[index]`, XOR it into the running checksum, index += 1.
  - When index reaches L -> CHECK.
- CHECK:
  - Byte == running XOR -> DRAIN, read pointer := 0.
  - Else pulse `err_checksum` and go to IDLE. Buffer contents are discarded.
- DRAIN:
  - `pkt_valid`=1, `pkt_data`=`buf[rd]`, `pkt_last`=(rd == L-1).
  - On `pkt_valid && pkt_ready`: rd += 1.
  - On the transfer with `pkt_last`: go to IDLE.
  - Any `rx_valid` in DRAIN: byte dropped, including a sync byte, and `err_overrun` pulses.
- `pkt_len` = L, held stable throughout DRAIN; 0 in IDLE.
- A sync byte appearing inside LEN/PAYLOAD/CHECK is treated as data. There is no resync mid-frame.

## Timing
- Reset values (async on `rst_n` low):
  - State IDLE; outputs `pkt_valid`, `pkt_last`, `pkt_len`, `pkt_data`, `busy` and all `err_*` = 0.
  - Counters and checksum = 0. Buffer contents undefined.
- Reset mid-frame or mid-drain aborts immediately. No error pulses are emitted.
- All outputs are registered.
- Error pulses:
  - Each `err_*` pulse is high exactly 1 cycle.
  - It asserts on the cycle after the offending `rx_valid` or the timeout expiry.
- Latency: `pkt_valid` rises on the cycle after the checksum byte's `rx_valid`. First byte = `buf[0]`.
- Handshake:
  - `pkt_data` and `pkt_last` are stable while `pkt_valid && !pkt_ready`.
  - `pkt_valid` stays asserted until the transfer completes.
  - Throughput is 1 byte/clock when `pkt_ready`=1.
  - `pkt_valid` drops on the cycle after the last transfer.
- Timeout (LEN/PAYLOAD/CHECK only):
  - The counter clears on entry and on each `rx_valid`, and increments otherwise.
  - Reaching `TIMEOUT_CLKS-1` pulses `err_timeout` and goes to IDLE.
  - If `rx_valid` coincides with expiry, the byte wins and no timeout fires.
  - No timeout applies in IDLE or DRAIN.

## Configuration
- `UART_PKT_TIMEOUT_EN` defined:
  - Inter-byte timeout counter (24-bit) present, behaviour as above.
- Undefined:
  - No counter logic.
  - `err_timeout` tied 0.
  - A stalled frame waits indefinitely in LEN/PAYLOAD/CHECK until reset or further bytes arrive.

## Test plan
- Good packet, `pkt_ready`=1: bytes A5,03,11,22,33,03 -> `pkt_data` 11,22,33 on consecutive cycles. `pkt_last` on 33, `pkt_len`=3, no errors, back to IDLE.
- Bad checksum: A5,02,10,20,00 -> `err_checksum` one pulse, `pkt_valid` never asserts. Then A5,01,7E,7F -> single byte 7E delivered.
- Length errors: A5,00 and A5,11 (`MAX_LEN`=16) -> one `err_length` pulse each. A5,10 + 16 bytes + correct XOR -> 16 bytes out.
- Backpressure and overrun:
  - Good 4-byte packet with `pkt_ready` toggling 1,0,0,1 -> data held stable while stalled, all 4 bytes delivered in order.
  - An A5 received during DRAIN -> `err_overrun` pulse, the byte is not treated as a new frame.
- Timeout (`UART_PKT_TIMEOUT_EN`, `TIMEOUT_CLKS`=20): A5,02,55 then idle -> `err_timeout` 20 cycles after 55, `busy`=0.
  - `rx_valid` exactly on the expiry cycle -> no pulse, frame continues.
- Reset mid-PAYLOAD: `rst_n` low for 1 cycle after A5,04,01 -> all outputs 0 immediately. A following good packet is received correctly.
